// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer with valid/ready handshakes. A round-robin
// (or fixed-priority) arbiter selects one requester per cycle into one output register.
module rr_mux_arb #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int FIXED_PRIO = 0,
  parameter int SELW       = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  output logic [NUM_CH-1:0]         in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);

  localparam logic [SELW-1:0]   LAST_CH = SELW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE_HOT = NUM_CH'(1);

  logic [SELW-1:0]  last;
  logic [SELW-1:0]  grant;
  logic             found;
  int               idx;
  logic             any_req;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  assign any_req = |in_valid;
  assign load    = !out_valid || out_ready;

  // Scan starts one past the previous winner, so the last winner has lowest priority.
  // NOTE: every variable gets a default before the branches, otherwise the
  // paths that leave it unassigned infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (FIXED_PRIO != 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant = SELW'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = int'(last) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          grant = SELW'(idx);
        end
      end
    end
  end

  // Held low during reset so no producer believes a word was taken.
  assign in_ready = (!reset && load && found) ? (ONE_HOT << grant) : '0;
  assign sel_data = in_data[grant*WIDTH +: WIDTH];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= LAST_CH;
    end else if (load) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant;
        last      <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: round-robin and fixed-priority 4-channel
// instances plus a 3-channel, 16-bit round-robin instance.
module tb_rr_mux_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  v4;
  logic [31:0] d4;
  logic        r4;
  logic [3:0]  rdy4, rdyf;
  logic        ov4, ovf;
  logic [7:0]  od4, odf;
  logic [1:0]  os4, osf;

  logic [2:0]  v3;
  logic [47:0] d3;
  logic        r3;
  logic [2:0]  rdy3;
  logic        ov3;
  logic [15:0] od3;
  logic [1:0]  os3;

  int errors = 0;
  int checks = 0;

  rr_mux_arb #(.NUM_CH(4), .WIDTH(8), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(r4));

  rr_mux_arb #(.NUM_CH(4), .WIDTH(8), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset), .in_valid(v4), .in_data(d4), .in_ready(rdyf),
    .out_valid(ovf), .out_data(odf), .out_sel(osf), .out_ready(r4));

  rr_mux_arb #(.NUM_CH(3), .WIDTH(16), .FIXED_PRIO(0)) dut_3 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(r3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
  endtask

  logic [7:0] seq_data [5];
  logic [3:0] seq_rdy  [5];
  logic [1:0] alt_sel  [4];

  initial begin
    seq_data = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    seq_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    alt_sel  = '{2'd0, 2'd2, 2'd0, 2'd2};

    reset = 1'b1;
    v4 = 4'b1111;
    d4 = 32'h43_32_21_10;
    r4 = 1'b1;
    v3 = '0;
    d3 = '0;
    r3 = 1'b1;

    // Reset held across clock edges with every channel requesting.
    tick();
    tick();
    check("rst_valid", 32'(ov4), 32'd0);
    check("rst_data", 32'(od4), 32'h0);
    check("rst_sel", 32'(os4), 32'd0);
    check("rst_ready", 32'(rdy4), 32'h0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    // All four valid: grants cycle 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_ready%0d", i), 32'(rdy4), 32'(seq_rdy[i]));
      tick();
      check($sformatf("rr_data%0d", i), 32'(od4), 32'(seq_data[i]));
      check($sformatf("rr_valid%0d", i), 32'(ov4), 32'd1);
      check($sformatf("fp_data%0d", i), 32'(odf), 32'h10);
    end

    // Alternating 0101 requests.
    pulse_reset();
    v4 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("alt_sel%0d", i), 32'(os4), 32'(alt_sel[i]));
      check($sformatf("fp_alt_sel%0d", i), 32'(osf), 32'd0);
    end

    // Stall holds A5 from ch1 while ch2 waits.
    pulse_reset();
    v4 = 4'b0010;
    d4 = 32'h00_5A_A5_00;
    tick();
    check("ld_a5", 32'(od4), 32'hA5);
    r4 = 1'b0;
    v4 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_ready%0d", i), 32'(rdy4), 32'h0);
      tick();
      check($sformatf("stall_data%0d", i), 32'(od4), 32'hA5);
      check($sformatf("stall_sel%0d", i), 32'(os4), 32'd1);
      check($sformatf("stall_valid%0d", i), 32'(ov4), 32'd1);
    end
    r4 = 1'b1;
    #1;
    check("unstall_ready", 32'(rdy4), 32'b0100);
    tick();
    check("unstall_data", 32'(od4), 32'h5A);
    check("unstall_sel", 32'(os4), 32'd2);
    check("unstall_valid", 32'(ov4), 32'd1);

    // Single ch3 word then idle: one valid cycle, data held after drain.
    pulse_reset();
    v4 = 4'b1000;
    d4 = 32'hFF_00_00_00;
    tick();
    check("one_valid", 32'(ov4), 32'd1);
    check("one_data", 32'(od4), 32'hFF);
    check("one_sel", 32'(os4), 32'd3);
    v4 = 4'b0000;
    tick();
    check("drain_valid", 32'(ov4), 32'd0);
    check("drain_data", 32'(od4), 32'hFF);
    tick();
    check("idle_valid", 32'(ov4), 32'd0);

    // Asynchronous reset mid-cycle while a word is held.
    v4 = 4'b0001;
    d4 = 32'h00_00_00_77;
    tick();
    check("pre_async_valid", 32'(ov4), 32'd1);
    r4 = 1'b0;
    v4 = 4'b0000;
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(ov4), 32'd0);
    check("async_data", 32'(od4), 32'h0);
    check("async_sel", 32'(os4), 32'd0);
    #1 reset = 1'b0;
    r4 = 1'b1;
    v4 = 4'b1001;
    d4 = 32'h99_00_00_66;
    #1;
    check("post_async_ready", 32'(rdy4), 32'b0001);
    tick();
    check("post_async_sel", 32'(os4), 32'd0);
    check("post_async_data", 32'(od4), 32'h66);

    // Three-channel wrap-around.
    v4 = 4'b0000;
    pulse_reset();
    v3 = 3'b111;
    d3 = 48'h3222_2111_1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("n3_sel%0d", i), 32'(os3), 32'(i % 3));
      check($sformatf("n3_data%0d", i), 32'(od3), 32'(16'h1000 + 16'h1111 * (i % 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
